spec_acc_scheduler: RTL and testbench
=====================================

# spec_acc_scheduler

Sequences multi-pulse spectrum accumulation in the range-bin DPRAM and drains the result. It counts range bins within a pulse and pulses within a frame, and it tells the accumulator when to overwrite rather than accumulate. After the last pulse it reads the whole accumulated spectrum out to the upload path with a ready handshake. It sits between the trigger/configuration logic and the accumulator's address/control logic.

## Interface
Parameters:
- IDX_W, 10, FFT point index width (1024-point spectra)
- BIN_W, 5, range-bin counter width
- PLS_W, 16, pulse counter width
- RD_LAT, 2, DPRAM read latency in cycles

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and begins a frame
- abort  in  1  synchronous; returns to IDLE from any state
- num_bins  in  BIN_W  range bins per pulse (valid 1..2^BIN_W-1)
- num_pulses  in  PLS_W  pulses to accumulate (valid 1..2^PLS_W-1)
- trig_in  in  1  laser pulse trigger, one-cycle
- acc_done  in  1  one-cycle pulse from accumulator: current bin finished
- up_ready  in  1  upload path can accept reads
- RangeBin_Counter  out  BIN_W  current bin to accumulator
- acc_first  out  1  1 = first pulse of frame: write, do not add old contents
- rd_addr  out  BIN_W+IDX_W  readout address {bin, index}
- rd_en  out  1  readout DPRAM read strobe
- out_valid  out  1  rd_en delayed RD_LAT cycles; DPRAM data valid
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of readout
- cfg_err  out  1  one-cycle pulse: start with num_bins==0 or num_pulses==0
- trig_miss  out  1  one-cycle pulse: trig_in while not in WAIT_TRIG and busy

## Operation
- States: IDLE, WAIT_TRIG, ACQ, READOUT, DRAIN, DONE.
- IDLE:
  - start with both counts nonzero: latch nb=num_bins and np=num_pulses, set pulse_cnt=0, go to WAIT_TRIG.
  - start with either count zero: pulse cfg_err, stay in IDLE.
- WAIT_TRIG: trig_in sets RangeBin_Counter=0 and goes to ACQ.
- ACQ:
  - acc_done increments RangeBin_Counter.
  - acc_done when RangeBin_Counter==nb-1:
    - if pulse_cnt==np-1: go to READOUT with rd_addr=0.
    - otherwise: pulse_cnt++ and go to WAIT_TRIG.
- acc_first = (pulse_cnt==0), registered; it holds for the entire first pulse.
- READOUT:
  - rd_en=1 in every cycle where up_ready=1; rd_addr advances by 1 after each rd_en.
  - Address order is index 0..1023 of bin 0, then bin 1, and so on; the last address is {nb-1, 1023}.
  - rd_en on the last address goes to DRAIN.
- DRAIN: waits RD_LAT cycles so the final out_valid is emitted, then goes to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- The upload side must absorb up to RD_LAT words in flight after deasserting up_ready; up_ready only gates new reads.
- trig_in in ACQ, READOUT, DRAIN or DONE: ignored, trig_miss pulsed. trig_in in IDLE: ignored silently.
- acc_done outside ACQ: ignored.
- start while busy: ignored. Config inputs are sampled only on an accepted start.
- abort or rst mid-frame: immediate IDLE, all counters cleared, rd_en=0. The out_valid pipeline is flushed to 0. DPRAM contents are left unchanged; the next frame's acc_first overwrites them.
- abort and start in the same cycle: abort wins.

## Timing
- All outputs are registered. Reset/abort values:
  - RangeBin_Counter=0, rd_addr=0
  - acc_first=1
  - rd_en=0, out_valid=0, busy=0
  - frame_done=0, cfg_err=0, trig_miss=0
- start to busy=1: 1 cycle.
- trig_in to ACQ: next cycle; RangeBin_Counter=0 is valid the same edge.
- acc_done at cycle t: RangeBin_Counter updated at t+1.
- Final acc_done at t: rd_en can first assert at t+2 (READOUT entered at t+1, rd_en registered).
- out_valid(t) = rd_en(t-RD_LAT) exactly.
- Full readout with up_ready held high: nb*1024 consecutive rd_en cycles, then RD_LAT drain cycles, then a frame_done pulse.
- Counter widths: rd_addr wraps naturally only at {nb-1,1023}, which is terminal. pulse_cnt never exceeds np-1.

## Test plan
- Reset, then idle: all outputs at reset values; busy=0; no rd_en for 100 cycles.
- start nb=3, np=2; trig, 3 acc_done; trig, 3 acc_done: acc_first=1 for pulse 0 and 0 for pulse 1. RangeBin_Counter steps 0,1,2 per pulse. Readout gives 3072 rd_en with addresses 0..3071, then frame_done 3 cycles after the last rd_en.
- Readout with up_ready toggled 1-0 alternately: rd_addr increments only on rd_en. out_valid matches rd_en shifted 2 cycles, with no duplicated or skipped address.
- start with num_pulses=0: cfg_err pulse, busy stays 0. Then start nb=1, np=1: one trig and one acc_done lead to 1024 reads.
- trig_in during ACQ of nb=4: trig_miss pulse; the bin sequence is unaffected and pulse_cnt is unchanged.
- abort asserted mid-READOUT at address 500: next cycle IDLE, rd_en=0, out_valid=0 within 1 cycle, no frame_done. A new start then runs normally with acc_first=1.

Source files
------------

// File: rtl/spec_acc_scheduler.sv
// spec_acc_scheduler
//   Sequences multi-pulse spectrum accumulation in the range-bin DPRAM and
//   then drains the accumulated spectrum to the upload path.
//
//   Frame flow: IDLE -> WAIT_TRIG -> ACQ (one pass per pulse) -> ... ->
//   READOUT -> DRAIN -> DONE -> IDLE.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, latches num_bins/num_pulses
//   abort             synchronous return to IDLE from any state
//   num_bins          range bins per pulse (1..2^BIN_W-1)
//   num_pulses        pulses per frame (1..2^PLS_W-1)
//   trig_in           laser trigger, starts one pulse of acquisition
//   acc_done          accumulator finished the current bin
//   up_ready          upload path may accept a new read
//   RangeBin_Counter  current bin presented to the accumulator
//   acc_first         first pulse of frame: overwrite instead of add
//   rd_addr, rd_en    readout address {bin, index} and read strobe
//   out_valid         rd_en delayed by RD_LAT (DPRAM data valid)
//   busy              any state other than IDLE
//   frame_done        one-cycle pulse after the final out_valid
//   cfg_err           start rejected because a count was zero
//   trig_miss         trigger arrived outside WAIT_TRIG while busy

module spec_acc_scheduler #(
  parameter int IDX_W  = 10,
  parameter int BIN_W  = 5,
  parameter int PLS_W  = 16,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [BIN_W-1:0]       num_bins,
  input  logic [PLS_W-1:0]       num_pulses,
  input  logic                   trig_in,
  input  logic                   acc_done,
  input  logic                   up_ready,
  output logic [BIN_W-1:0]       RangeBin_Counter,
  output logic                   acc_first,
  output logic [BIN_W+IDX_W-1:0] rd_addr,
  output logic                   rd_en,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err,
  output logic                   trig_miss
);

  localparam int ADDR_W = BIN_W + IDX_W;
  localparam int DR_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TRIG = 3'd1;
  localparam logic [2:0] S_ACQ       = 3'd2;
  localparam logic [2:0] S_READOUT   = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [BIN_W-1:0]  nb_m1;      // latched num_bins - 1
  logic [PLS_W-1:0]  np_m1;      // latched num_pulses - 1
  logic [PLS_W-1:0]  pulse_cnt;
  logic [DR_W-1:0]   drain_cnt;
  logic [RD_LAT-1:0] vld_pipe;   // bit i = rd_en delayed i+1 cycles

  logic cfg_ok, bin_last, pulse_last, addr_last, drain_last;

  assign cfg_ok     = (num_bins != '0) && (num_pulses != '0);
  assign bin_last   = (RangeBin_Counter == nb_m1);
  assign pulse_last = (pulse_cnt == np_m1);
  assign addr_last  = (rd_addr == {nb_m1, {IDX_W{1'b1}}});
  assign drain_last = (drain_cnt == DR_W'(RD_LAT - 1));
  assign out_valid  = vld_pipe[RD_LAT-1];

  // NOTE: state_nxt gets a default before the case so every path assigns
  // it; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start && cfg_ok) state_nxt = S_WAIT_TRIG;
        S_WAIT_TRIG: if (trig_in) state_nxt = S_ACQ;
        S_ACQ:       if (acc_done && bin_last)
                       state_nxt = pulse_last ? S_READOUT : S_WAIT_TRIG;
        S_READOUT:   if (rd_en && addr_last) state_nxt = S_DRAIN;
        S_DRAIN:     if (drain_last) state_nxt = S_DONE;
        S_DONE:      state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      // Abort flushes everything, including in-flight out_valid; the DPRAM
      // is untouched because the next frame's acc_first overwrites it.
      state            <= S_IDLE;
      nb_m1            <= '0;
      np_m1            <= '0;
      pulse_cnt        <= '0;
      drain_cnt        <= '0;
      vld_pipe         <= '0;
      RangeBin_Counter <= '0;
      acc_first        <= 1'b1;
      rd_addr          <= '0;
      rd_en            <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      cfg_err          <= 1'b0;
      trig_miss        <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      frame_done <= (state_nxt == S_DONE);
      cfg_err    <= (state == S_IDLE) && start && !cfg_ok;
      trig_miss  <= trig_in && (state == S_ACQ || state == S_READOUT ||
                                state == S_DRAIN || state == S_DONE);
      // A read is issued only while staying in READOUT, so the cycle that
      // issues the last address never issues another.
      rd_en      <= (state == S_READOUT) && (state_nxt == S_READOUT) && up_ready;
      vld_pipe   <= (vld_pipe << 1) | RD_LAT'(rd_en);
      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + DR_W'(1) : '0;

      case (state)
        S_IDLE: begin
          if (start && cfg_ok) begin
            nb_m1     <= num_bins - BIN_W'(1);
            np_m1     <= num_pulses - PLS_W'(1);
            pulse_cnt <= '0;
            acc_first <= 1'b1;
            rd_addr   <= '0;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_in) RangeBin_Counter <= '0;
        end
        S_ACQ: begin
          if (acc_done) begin
            if (bin_last) begin
              RangeBin_Counter <= '0;
              if (pulse_last) begin
                rd_addr <= '0;
              end else begin
                pulse_cnt <= pulse_cnt + PLS_W'(1);
                acc_first <= 1'b0;
              end
            end else begin
              RangeBin_Counter <= RangeBin_Counter + BIN_W'(1);
            end
          end
        end
        S_READOUT: begin
          // The address moves only after a read is issued; the last address
          // is terminal and is held.
          if (rd_en && !addr_last) rd_addr <= rd_addr + ADDR_W'(1);
        end
        S_DONE: begin
          pulse_cnt <= '0;
          acc_first <= 1'b1;
          rd_addr   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spec_acc_scheduler.sv
// tb_spec_acc_scheduler
//   Directed testbench for spec_acc_scheduler. Inputs are driven 1 ns after
//   the rising edge and outputs are observed at the same point, so each
//   step() shows the result of exactly one clock edge.

module tb_spec_acc_scheduler;

  localparam int IDX_W  = 10;
  localparam int BIN_W  = 5;
  localparam int PLS_W  = 16;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = BIN_W + IDX_W;

  logic              clk = 1'b0;
  logic              rst, start, abort, trig_in, acc_done, up_ready;
  logic [BIN_W-1:0]  num_bins;
  logic [PLS_W-1:0]  num_pulses;
  logic [BIN_W-1:0]  RangeBin_Counter;
  logic              acc_first, rd_en, out_valid, busy;
  logic              frame_done, cfg_err, trig_miss;
  logic [ADDR_W-1:0] rd_addr;

  int passed = 0;
  int total  = 0;

  spec_acc_scheduler #(
    .IDX_W(IDX_W), .BIN_W(BIN_W), .PLS_W(PLS_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_bins(num_bins), .num_pulses(num_pulses),
    .trig_in(trig_in), .acc_done(acc_done), .up_ready(up_ready),
    .RangeBin_Counter(RangeBin_Counter), .acc_first(acc_first),
    .rd_addr(rd_addr), .rd_en(rd_en), .out_valid(out_valid), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err), .trig_miss(trig_miss)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int nb, input int np);
    num_bins   = BIN_W'(nb);
    num_pulses = PLS_W'(np);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // One pulse of acquisition: trigger, then one acc_done per bin.
  task automatic run_acq(input int nb, input logic exp_first, input string tag);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    for (int b = 0; b < nb; b++) begin
      total++;
      if (RangeBin_Counter !== BIN_W'(b))
        $display("FAIL %s_bin%0d: RangeBin_Counter=%0d expected %0d", tag, b, RangeBin_Counter, b);
      else passed++;
      total++;
      if (acc_first !== exp_first)
        $display("FAIL %s_acc_first_bin%0d: acc_first=%b expected %b", tag, b, acc_first, exp_first);
      else passed++;
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
    end
  endtask

  // Called right after the final acc_done edge (READOUT just entered).
  task automatic run_readout(input int exp_words, input bit toggle, input string tag);
    int   exp_addr = 0;
    int   words    = 0;
    int   addr_err = 0;
    int   ov_err   = 0;
    int   first_c  = -1;
    int   last_c   = -1;
    int   fd_c     = -1;
    logic r1, r2;
    r1 = rd_en;
    r2 = 1'b0;
    for (int c = 1; c <= 2 * exp_words + 20; c++) begin
      if (toggle) up_ready = ~up_ready;
      step();
      if (out_valid !== r2) ov_err++;
      r2 = r1;
      r1 = rd_en;
      if (exp_addr < exp_words && rd_addr !== ADDR_W'(exp_addr)) addr_err++;
      if (rd_en === 1'b1) begin
        words++;
        exp_addr++;
        last_c = c;
        if (first_c < 0) first_c = c;
      end
      if (frame_done === 1'b1) begin
        fd_c = c;
        break;
      end
    end
    up_ready = 1'b1;

    total++;
    if (words != exp_words)
      $display("FAIL %s_words: rd_en count=%0d expected %0d", tag, words, exp_words);
    else passed++;
    total++;
    if (addr_err != 0)
      $display("FAIL %s_addr_seq: %0d address errors, expected 0", tag, addr_err);
    else passed++;
    total++;
    if (ov_err != 0)
      $display("FAIL %s_out_valid: %0d cycles differ from rd_en delayed 2, expected 0", tag, ov_err);
    else passed++;
    total++;
    if (fd_c < 0 || fd_c - last_c != 3)
      $display("FAIL %s_frame_done: at cycle %0d, last rd_en %0d, expected gap 3", tag, fd_c, last_c);
    else passed++;
    if (!toggle) begin
      total++;
      if (first_c != 1)
        $display("FAIL %s_first_rd: first rd_en at cycle %0d expected 1", tag, first_c);
      else passed++;
    end
    step();
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_after_done: frame_done=%b busy=%b expected 0 0", tag, frame_done, busy);
    else passed++;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({RangeBin_Counter, rd_addr} !== '0 || acc_first !== 1'b1)
      $display("FAIL reset_regs: bin=%0d addr=%0d acc_first=%b expected 0 0 1",
               RangeBin_Counter, rd_addr, acc_first);
    else passed++;
    total++;
    if ({rd_en, out_valid, busy, frame_done, cfg_err, trig_miss} !== 6'b0)
      $display("FAIL reset_flags: rd_en,ov,busy,fd,cfg,miss=%b expected 000000",
               {rd_en, out_valid, busy, frame_done, cfg_err, trig_miss});
    else passed++;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rd_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL idle_quiet: %0d active cycles expected 0", bad);
    else passed++;
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    total++;
    if (trig_miss !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_trig: trig_miss=%b busy=%b expected 0 0", trig_miss, busy);
    else passed++;
  endtask

  task automatic test_basic();
    issue_start(3, 2);
    total++;
    if (busy !== 1'b1 || acc_first !== 1'b1)
      $display("FAIL basic_start: busy=%b acc_first=%b expected 1 1", busy, acc_first);
    else passed++;
    // A start while busy must be ignored; readout length proves nb stayed 3.
    issue_start(1, 1);
    total++;
    if (busy !== 1'b1 || cfg_err !== 1'b0)
      $display("FAIL basic_busy_start: busy=%b cfg_err=%b expected 1 0", busy, cfg_err);
    else passed++;
    run_acq(3, 1'b1, "basic_p0");
    run_acq(3, 1'b0, "basic_p1");
    total++;
    if (rd_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_readout_entry: rd_en=%b busy=%b expected 0 1", rd_en, busy);
    else passed++;
    run_readout(3072, 1'b0, "basic");
  endtask

  task automatic test_toggle();
    issue_start(2, 1);
    run_acq(2, 1'b1, "toggle");
    run_readout(2048, 1'b1, "toggle");
  endtask

  task automatic test_cfg_err();
    issue_start(3, 0);
    total++;
    if (cfg_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL cfg_np0: cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
    else passed++;
    step();
    total++;
    if (cfg_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL cfg_pulse: cfg_err=%b busy=%b expected 0 0", cfg_err, busy);
    else passed++;
    issue_start(0, 2);
    total++;
    if (cfg_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL cfg_nb0: cfg_err=%b busy=%b expected 1 0", cfg_err, busy);
    else passed++;
    issue_start(1, 1);
    total++;
    if (busy !== 1'b1 || cfg_err !== 1'b0)
      $display("FAIL cfg_ok_start: busy=%b cfg_err=%b expected 1 0", busy, cfg_err);
    else passed++;
    run_acq(1, 1'b1, "single");
    run_readout(1024, 1'b0, "single");
  endtask

  task automatic test_trig_miss();
    int bad = 0;
    issue_start(4, 2);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    total++;
    if (trig_miss !== 1'b1 || RangeBin_Counter !== BIN_W'(1))
      $display("FAIL miss_pulse: trig_miss=%b bin=%0d expected 1 1", trig_miss, RangeBin_Counter);
    else passed++;
    step();
    total++;
    if (trig_miss !== 1'b0)
      $display("FAIL miss_one_cycle: trig_miss=%b expected 0", trig_miss);
    else passed++;
    for (int b = 1; b < 4; b++) begin
      total++;
      if (RangeBin_Counter !== BIN_W'(b))
        $display("FAIL miss_bin%0d: RangeBin_Counter=%0d expected %0d", b, RangeBin_Counter, b);
      else passed++;
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
    end
    // Pulse count unchanged by the stray trigger: a second pulse is still due.
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_en !== 1'b0 || busy !== 1'b1 || acc_first !== 1'b0) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL miss_wait_second: %0d cycles not waiting for pulse 1, expected 0", bad);
    else passed++;
    run_acq(4, 1'b0, "miss_p1");
    run_readout(4096, 1'b0, "miss");
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int bad   = 0;
    issue_start(1, 1);
    run_acq(1, 1'b1, "abort_pre");
    for (int c = 0; c < 600; c++) begin
      step();
      if (rd_en === 1'b1 && rd_addr === ADDR_W'(500)) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) $display("FAIL abort_reach500: address 500 not read, expected it");
    else passed++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({busy, rd_en, out_valid} !== 3'b000 || rd_addr !== '0 || acc_first !== 1'b1)
      $display("FAIL abort_state: busy,rd_en,ov=%b addr=%0d acc_first=%b expected 000 0 1",
               {busy, rd_en, out_valid}, rd_addr, acc_first);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL abort_quiet: %0d active cycles expected 0", bad);
    else passed++;
    num_bins   = BIN_W'(1);
    num_pulses = PLS_W'(1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL abort_wins: busy=%b cfg_err=%b expected 0 0", busy, cfg_err);
    else passed++;
    issue_start(1, 1);
    run_acq(1, 1'b1, "post_abort");
    run_readout(1024, 1'b0, "post_abort");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    trig_in    = 1'b0;
    acc_done   = 1'b0;
    up_ready   = 1'b1;
    num_bins   = '0;
    num_pulses = '0;
    test_reset();
    test_basic();
    test_toggle();
    test_cfg_err();
    test_trig_miss();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
